// File: rtl/multicon_reg_arb.sv
// Two-requester round-robin arbiter for the multi-function controller register
// port, with a bounded ownership lock and latency-aligned read-data steering.
module multicon_reg_arb #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned MAX_LOCK   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_req0,
   input  logic                      i_req1,
   input  logic                      i_we0,
   input  logic                      i_we1,
   input  logic [ADDR_WIDTH-1:0]     i_addr0,
   input  logic [ADDR_WIDTH-1:0]     i_addr1,
   input  logic [DATA_WIDTH/8-1:0]   i_be0,
   input  logic [DATA_WIDTH/8-1:0]   i_be1,
   input  logic [DATA_WIDTH-1:0]     i_wdata0,
   input  logic [DATA_WIDTH-1:0]     i_wdata1,
   input  logic                      i_lock0,
   input  logic                      i_lock1,
   output logic                      o_gnt0,
   output logic                      o_gnt1,
   output logic                      o_rvalid0,
   output logic                      o_rvalid1,
   output logic [DATA_WIDTH-1:0]     o_rdata0,
   output logic [DATA_WIDTH-1:0]     o_rdata1,
   output logic                      o_reg_req,
   output logic                      o_reg_we,
   output logic [ADDR_WIDTH-1:0]     o_reg_addr,
   output logic [DATA_WIDTH/8-1:0]   o_reg_be,
   output logic [DATA_WIDTH-1:0]     o_reg_wdata,
   input  logic [DATA_WIDTH-1:0]     i_reg_rdata
);

   localparam int unsigned CNT_WIDTH = $clog2(MAX_LOCK + 1);

   typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} lock_state_e;

   lock_state_e           state, state_nxt;
   logic                  lock_owner, lock_owner_nxt;
   logic [CNT_WIDTH-1:0]  lock_cnt, lock_cnt_nxt;
   logic                  last_owner;
   logic                  gnt_any, gnt_idx, gnt_lock, gnt_we, owner_req;
   logic [RD_LATENCY-1:0] pipe_vld, pipe_own;

   // State register: lock FSM, lock bookkeeping and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_UNLOCKED;
         lock_owner <= 1'b0;
         lock_cnt   <= '0;
         last_owner <= 1'b1;
      end else begin
         state      <= state_nxt;
         lock_owner <= lock_owner_nxt;
         lock_cnt   <= lock_cnt_nxt;
         if (gnt_any) last_owner <= gnt_idx;
      end
   end

   // Next-state: enter lock on a locked grant, release on drop, abandon or limit
   always_comb begin
      state_nxt      = state;
      lock_owner_nxt = lock_owner;
      lock_cnt_nxt   = lock_cnt;
      unique case (state)
         ST_UNLOCKED: begin
            if (gnt_any && gnt_lock && (MAX_LOCK > 1)) begin
               state_nxt      = ST_LOCKED;
               lock_owner_nxt = gnt_idx;
               lock_cnt_nxt   = CNT_WIDTH'(1);
            end
         end
         ST_LOCKED: begin
            if (!owner_req || !gnt_lock || (lock_cnt == CNT_WIDTH'(MAX_LOCK - 1))) begin
               state_nxt    = ST_UNLOCKED;
               lock_cnt_nxt = '0;
            end else begin
               lock_cnt_nxt = CNT_WIDTH'(lock_cnt + CNT_WIDTH'(1));
            end
         end
         default: begin
            state_nxt    = ST_UNLOCKED;
            lock_cnt_nxt = '0;
         end
      endcase
   end

   // Output: grant selection and downstream mux of the granted requester
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = 1'b0;
      owner_req = lock_owner ? i_req1 : i_req0;
      if (state == ST_LOCKED) begin
         gnt_any = owner_req;
         gnt_idx = lock_owner;
      end else if (i_req0 && i_req1) begin
         gnt_any = 1'b1;
         gnt_idx = ~last_owner;
      end else if (i_req0 || i_req1) begin
         gnt_any = 1'b1;
         gnt_idx = i_req1;
      end
      gnt_lock    = gnt_idx ? i_lock1 : i_lock0;
      gnt_we      = gnt_idx ? i_we1 : i_we0;
      o_gnt0      = gnt_any & ~gnt_idx;
      o_gnt1      = gnt_any & gnt_idx;
      o_reg_req   = gnt_any;
      o_reg_we    = gnt_any & gnt_we;
      o_reg_addr  = o_gnt1 ? i_addr1  : i_addr0;
      o_reg_be    = o_gnt1 ? i_be1    : i_be0;
      o_reg_wdata = o_gnt1 ? i_wdata1 : i_wdata0;
   end

   // Read-return pipeline: tail lines up with downstream read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         pipe_own <= '0;
      end else begin
         pipe_vld[0] <= gnt_any & ~gnt_we;
         pipe_own[0] <= gnt_idx;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_own[i] <= pipe_own[i-1];
         end
      end
   end

   assign o_rvalid0 = pipe_vld[RD_LATENCY-1] & ~pipe_own[RD_LATENCY-1];
   assign o_rvalid1 = pipe_vld[RD_LATENCY-1] &  pipe_own[RD_LATENCY-1];
   assign o_rdata0  = i_reg_rdata;
   assign o_rdata1  = i_reg_rdata;

endmodule
